// File: rtl/div_ctrl.sv
// Execute-stage sequencer wrapping a combinational unsigned divider: takes RISC-V
// DIV/DIVU/REM/REMU, feeds magnitudes, waits a settle window, then fixes signs.
module div_ctrl #(
  parameter int XLEN          = 32,
  parameter int SETTLE_CYCLES = 4,
  parameter int TAG_W         = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic [XLEN-1:0]  div_dividend,
  output logic [XLEN-1:0]  div_divisor,
  input  logic [XLEN-1:0]  div_quotient,
  input  logic [XLEN-1:0]  div_remainder,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [XLEN-1:0]  dvd_q, dvd_d, dvs_q, dvs_d;
  logic [XLEN-1:0]  res_q, res_d;

  // op[0] = unsigned, op[1] = remainder
  logic            in_signed, in_rem, in_sa, in_sb, in_div0, in_ovf;
  logic [XLEN-1:0] in_mag_a, in_mag_b, in_special, fix_res;

  always_comb begin
    in_signed  = ~in_op[0];
    in_rem     = in_op[1];
    in_sa      = in_signed & in_rs1[XLEN-1];
    in_sb      = in_signed & in_rs2[XLEN-1];
    in_mag_a   = in_sa ? (XLEN'(0) - in_rs1) : in_rs1;
    in_mag_b   = in_sb ? (XLEN'(0) - in_rs2) : in_rs2;
    in_div0    = (in_rs2 == '0);
    in_ovf     = in_signed && (in_rs1 == INT_MIN) && (in_rs2 == '1);
    if (in_div0) in_special = in_rem ? in_rs1 : '1;
    else         in_special = in_rem ? '0 : INT_MIN;
  end

  // Sign flags are zero for unsigned ops, so the same negate rule covers all four.
  always_comb begin
    if (op_q[1]) fix_res = sign_a_q ? (XLEN'(0) - div_remainder) : div_remainder;
    else         fix_res = (sign_a_q ^ sign_b_q) ? (XLEN'(0) - div_quotient) : div_quotient;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    tag_d    = tag_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    res_d    = res_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d     = in_op;
          tag_d    = in_tag;
          sign_a_d = in_sa;
          sign_b_d = in_sb;
          dvd_d    = in_mag_a;
          dvs_d    = in_mag_b;
          if (in_div0 || in_ovf) begin
            res_d   = in_special;
            state_d = S_DONE;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (cnt_q == '0) begin
          res_d   = fix_res;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      tag_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      tag_q    <= tag_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      res_q    <= res_d;
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign out_valid    = (state_q == S_DONE);
  assign div_dividend = dvd_q;
  assign div_divisor  = dvs_q;
  assign out_result   = res_q;
  assign out_tag      = tag_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: a behavioural divider stands in for the real unit,
// and each vector carries its hand-computed result and edge latency.
module tb_div_ctrl;

  localparam int XLEN = 32;
  localparam int TAG_W = 5;

  logic             clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]       in_op;
  logic [XLEN-1:0]  in_rs1, in_rs2, div_dividend, div_divisor, div_quotient, div_remainder, out_result;
  logic [TAG_W-1:0] in_tag, out_tag;

  int checks = 0;
  int errors = 0;

  div_ctrl #(.XLEN(XLEN), .SETTLE_CYCLES(4), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag)
  );

  assign div_quotient  = (div_divisor == '0) ? '1 : div_dividend / div_divisor;
  assign div_remainder = (div_divisor == '0) ? div_dividend : div_dividend % div_divisor;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives one op; accept edge counts as edge 1. hold = cycles out_ready stays low in DONE.
  task automatic run_op(input string name, input logic [1:0] op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tg,
                        input logic [XLEN-1:0] exp_res, input int exp_lat,
                        input logic [XLEN-1:0] exp_dvd, input logic [XLEN-1:0] exp_dvs, input int hold);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b; in_tag = tg;
    do begin
      @(posedge clk); #1;
      n++;
      in_valid = 1'b0;
      in_op = ~op; in_rs1 = ~a; in_rs2 = 32'h1; in_tag = ~tg;
      if (exp_lat > 1 && !out_valid) begin
        chk({name, "_dvd"}, div_dividend, exp_dvd);
        chk({name, "_dvs"}, div_divisor, exp_dvs);
      end
    end while (!out_valid && n < 20);
    chk({name, "_lat"}, XLEN'(n), XLEN'(exp_lat));
    chk({name, "_res"}, out_result, exp_res);
    chk({name, "_tag"}, XLEN'(out_tag), XLEN'(tg));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({name, "_hold_vld"}, XLEN'(out_valid), 32'd1);
      chk({name, "_hold_rdy"}, XLEN'(in_ready), 32'd0);
      chk({name, "_hold_res"}, out_result, exp_res);
      chk({name, "_hold_tag"}, XLEN'(out_tag), XLEN'(tg));
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, "_ret_rdy"}, XLEN'(in_ready), 32'd1);
    chk({name, "_ret_vld"}, XLEN'(out_valid), 32'd0);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_rs1 = '0; in_rs2 = '0; in_tag = '0;
    #12;
    chk("rst_in_ready", XLEN'(in_ready), 32'd1);
    chk("rst_out_valid", XLEN'(out_valid), 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_tag", XLEN'(out_tag), 32'd0);
    chk("rst_dvd", div_dividend, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd3, 32'd14, 5, 32'd100, 32'd7, 0);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd4, 32'd2,  5, 32'd100, 32'd7, 0);
    run_op("div_m7_2",   2'b00, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFD, 5, 32'd7, 32'd2, 0);
    run_op("rem_m7_2",   2'b10, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF, 5, 32'd7, 32'd2, 0);
    run_op("rem_7_m2",   2'b10, 32'd7, 32'hFFFFFFFE, 5'd7, 32'd1, 5, 32'd7, 32'd2, 0);
    run_op("divu_5_0",   2'b01, 32'd5, 32'd0, 5'd8, 32'hFFFFFFFF, 1, 32'd0, 32'd0, 0);
    run_op("remu_5_0",   2'b11, 32'd5, 32'd0, 5'd9, 32'd5, 1, 32'd0, 32'd0, 0);
    run_op("div_m7_0",   2'b00, 32'hFFFFFFF9, 32'd0, 5'd10, 32'hFFFFFFFF, 1, 32'd0, 32'd0, 0);
    run_op("div_ovf",    2'b00, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1, 32'd0, 32'd0, 0);
    run_op("rem_ovf",    2'b10, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0, 1, 32'd0, 32'd0, 0);
    run_op("divu_big",   2'b01, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'd0, 5, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op("div_min_3",  2'b00, 32'h80000000, 32'd3, 5'd14, 32'hD5555556, 5, 32'h80000000, 32'd3, 0);
    // Stall in DONE, then back-to-back op straight after release.
    run_op("stall_divu", 2'b01, 32'd1000, 32'd10, 5'd15, 32'd100, 5, 32'd1000, 32'd10, 3);
    run_op("b2b_rem",    2'b10, 32'hFFFFFF9C, 32'd7, 5'd16, 32'hFFFFFFFE, 5, 32'd100, 32'd7, 0);

    // Flush in the second CALC cycle.
    @(negedge clk);
    in_valid = 1'b1; in_op = 2'b01; in_rs1 = 32'd50; in_rs2 = 32'd5; in_tag = 5'd17;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush_in_ready", XLEN'(in_ready), 32'd1);
    chk("flush_out_valid", XLEN'(out_valid), 32'd0);
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (out_valid) seen++; end
    chk("flush_no_pulse", XLEN'(seen), 32'd0);

    // Flush wins over a concurrent request in IDLE.
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_op = 2'b01; in_rs1 = 32'd9; in_rs2 = 32'd3;
    @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0;
    chk("flush_idle_rdy", XLEN'(in_ready), 32'd1);
    seen = 0;
    repeat (6) begin @(posedge clk); #1; if (out_valid) seen++; end
    chk("flush_idle_nop", XLEN'(seen), 32'd0);

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    in_valid = 1'b1; in_op = 2'b00; in_rs1 = 32'hFFFFFFF9; in_rs2 = 32'd2; in_tag = 5'd18;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", XLEN'(in_ready), 32'd1);
    chk("arst_out_valid", XLEN'(out_valid), 32'd0);
    chk("arst_dvd", div_dividend, 32'd0);
    chk("arst_dvs", div_divisor, 32'd0);
    chk("arst_tag", XLEN'(out_tag), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (out_valid) seen++; end
    chk("arst_op_lost", XLEN'(seen), 32'd0);
    run_op("post_rst",   2'b01, 32'd81, 32'd9, 5'd19, 32'd9, 5, 32'd81, 32'd9, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Execute-stage sequencer for the combinational 32-bit unsigned `divide` unit.
- Accepts RISC-V M-extension divide ops (DIV/DIVU/REM/REMU) over a valid/ready handshake and converts signed operands to magnitudes.
- Drives the unsigned divider, holding operands stable for a multicycle settle window, then applies sign fix-up and RISC-V special cases.
- Returns a tagged result over a valid/ready handshake to writeback.

Parameters:
- XLEN, 32, operand/result width; must equal the divider width.
- SETTLE_CYCLES, 4, cycles the divider operands are held before the result is sampled; legal range >= 1.
- TAG_W, 5, width of the destination tag carried alongside the op.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of any in-flight op.
- in_valid  in  1  request valid.
- in_ready  out  1  request can be accepted.
- in_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- in_rs1  in  XLEN  dividend.
- in_rs2  in  XLEN  divisor.
- in_tag  in  TAG_W  destination tag.
- div_dividend  out  XLEN  unsigned dividend to the divider (registered).
- div_divisor  out  XLEN  unsigned divisor to the divider (registered).
- div_quotient  in  XLEN  divider quotient.
- div_remainder  in  XLEN  divider remainder.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  XLEN  final result.
- out_tag  out  TAG_W  tag of the result.

Behaviour:

Reset (rst_n low, asynchronous):
- state = IDLE; counter = 0.
- All outputs are 0 except in_ready = 1.

States: IDLE, CALC, DONE.
- in_ready = 1 only in IDLE.
- out_valid = 1 only in DONE.

IDLE:
- On in_valid, latch op, tag, sign_a = rs1[XLEN-1] and sign_b = rs2[XLEN-1]. Signs count only for DIV/REM; they are 0 for unsigned ops.
- div_dividend = |rs1| for signed ops, else rs1.
- div_divisor = |rs2| for signed ops, else rs2.
- Divide-by-zero (rs2 == 0) goes straight to DONE:
  - DIV/DIVU result = all ones.
  - REM/REMU result = rs1.
- Signed overflow (DIV/REM, rs1 == 0x80000000, rs2 == all ones) goes straight to DONE:
  - DIV result = 0x80000000.
  - REM result = 0.
- Otherwise go to CALC with counter = SETTLE_CYCLES-1.

CALC:
- div_dividend and div_divisor are held constant.
- The counter decrements each cycle.
- At counter == 0, on that clock edge, sample div_quotient/div_remainder, apply fix-up, and go to DONE.
- Fix-up for DIV: result = quotient, negated (two's complement) if sign_a XOR sign_b.
- Fix-up for REM: result = remainder, negated if sign_a.
- Fix-up for DIVU/REMU: raw quotient/remainder.
- |0x80000000| = 0x80000000 is a valid unsigned magnitude and needs no special handling.

DONE:
- out_result and out_tag are registered and stable while out_valid = 1 and out_ready = 0.
- On out_ready, go to IDLE.
- A new request is not accepted in the same cycle (no bypass).

Latency, counted from the accept edge:
- Normal op: out_valid rises SETTLE_CYCLES+1 edges later.
- Special case: out_valid rises 1 edge later.
- Throughput: one op per latency+1 cycles, minimum.

Flush:
- Highest priority in all states; next state is IDLE and out_valid drops next cycle.
- A concurrent in_valid in IDLE is ignored.
- Operand registers may keep their values; out_result/out_tag need not clear.

Reset mid-CALC or mid-DONE: immediate return to the reset values, and the op is lost.

in_op, in_rs1, in_rs2 and in_tag are sampled only on an accept edge; later changes have no effect.

Test Plan:
1. DIVU 100/7, tag 3, SETTLE_CYCLES=4 -> out_valid exactly 5 edges after accept, out_result 14, out_tag 3. REMU same operands -> 2.
2. DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3). REM same -> 0xFFFFFFFF (-1). REM 7 / 0xFFFFFFFE (-2) -> 1.
3. DIVU 5/0 -> 0xFFFFFFFF. REMU 5/0 -> 5. DIV 0xFFFFFFF9/0 -> 0xFFFFFFFF. Each with out_valid one edge after accept, and div_dividend/div_divisor never sampled.
4. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same -> 0. DIVU 0x80000000/0xFFFFFFFF -> 0 via the normal CALC path.
5. out_ready held low 3 cycles in DONE -> out_valid, out_result and out_tag stable, in_ready 0. Release -> IDLE, in_ready 1 next cycle, and a back-to-back op completes correctly.
6. Flush in the second CALC cycle -> IDLE next edge, no out_valid pulse. Separately, rst_n low mid-CALC -> outputs 0 and in_ready 1 immediately, without waiting for a clock edge.
